// File: rtl/instr_sequencer.sv
// instr_sequencer: program sequencer feeding the processor datapath.
// Holds a DEPTH-entry program memory and issues one instruction word at a
// time, paced by the processor's done handshake, with an abortable,
// restartable run and sticky completion status.
// Optional feature macro: SEQ_STEP_EN adds single-step pacing through the
// step_mode/step inputs.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4,
    parameter int GUARD = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [33:0]     prog_data,
    input  logic [PC_W:0]   prog_len,
    input  logic            start,
    input  logic            abort,
    input  logic            done,
`ifdef SEQ_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    output logic [2:0]      instr,
    output logic [4:0]      reg1,
    output logic [4:0]      reg2,
    output logic [4:0]      reg3,
    output logic [15:0]     imm,
    output logic            issue,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic [PC_W:0]   issued_cnt
);

    localparam int CNT_W = PC_W + 1;
    localparam int GC_W  = $clog2(GUARD + 1);
    localparam logic [GC_W-1:0] GUARD_LAST = GC_W'(GUARD - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_GUARD_WAIT = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_END        = 3'd4
    } state_t;

    logic [33:0]      mem [DEPTH];

    state_t           state_r,  state_s;
    logic [PC_W-1:0]  pc_r,     pc_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;
    logic [CNT_W-1:0] len_r,    len_s;
    logic [GC_W-1:0]  guard_r,  guard_s;
    logic [33:0]      fields_r, fields_s;
    logic             issue_r,  issue_s;
    logic             busy_r,   busy_s;
    logic             halted_r, halted_s;
    logic             abort_r,  abort_s;
    logic             step_ok_s;

`ifdef SEQ_STEP_EN
    logic             step_pend_r, step_pend_s;
    // In step mode an issue needs a live step pulse or one held from earlier.
    assign step_ok_s = !step_mode || step || step_pend_r;
`else
    assign step_ok_s = 1'b1;
`endif

    // Program memory: writable only while idle, not cleared by reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state_r == ST_IDLE)) begin
            mem[prog_addr] <= prog_data;
        end else begin
            mem[prog_addr] <= mem[prog_addr];
        end
    end

    // Next-state and next-output computation for the run FSM.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        cnt_s    = cnt_r;
        len_s    = len_r;
        guard_s  = guard_r;
        fields_s = fields_r;
        issue_s  = 1'b0;
        busy_s   = busy_r;
        halted_s = halted_r;
        // Abort is remembered from any busy cycle until the ISSUE decision.
        abort_s  = abort_r | (busy_r & abort);
`ifdef SEQ_STEP_EN
        step_pend_s = step_pend_r | (busy_r & step_mode & step);
`endif
        case (state_r)
            ST_IDLE: begin
                abort_s = 1'b0;
                if (start) begin
                    pc_s     = {PC_W{1'b0}};
                    cnt_s    = {CNT_W{1'b0}};
                    len_s    = prog_len;
                    halted_s = 1'b0;
                    busy_s   = 1'b1;
`ifdef SEQ_STEP_EN
                    step_pend_s = 1'b0;
`endif
                    if (prog_len != {CNT_W{1'b0}}) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_END;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort_s) begin
                    state_s = ST_END;
                end else if (done && step_ok_s) begin
                    fields_s = mem[pc_r];
                    issue_s  = 1'b1;
                    pc_s     = pc_r + PC_W'(1);
                    cnt_s    = cnt_r + CNT_W'(1);
                    guard_s  = {GC_W{1'b0}};
                    state_s  = ST_GUARD_WAIT;
`ifdef SEQ_STEP_EN
                    step_pend_s = 1'b0;
`endif
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_GUARD_WAIT: begin
                // done from the previous instruction may still be high here.
                if (guard_r == GUARD_LAST) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    guard_s = guard_r + GC_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    if (cnt_r == len_r) begin
                        state_s = ST_END;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_END: begin
                fields_s = 34'h0;
                busy_s   = 1'b0;
                halted_s = 1'b1;
                abort_s  = 1'b0;
                state_s  = ST_IDLE;
            end
            default: begin
                fields_s = 34'h0;
                busy_s   = 1'b0;
                abort_s  = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything except memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= {PC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            len_r    <= {CNT_W{1'b0}};
            guard_r  <= {GC_W{1'b0}};
            fields_r <= 34'h0;
            issue_r  <= 1'b0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            abort_r  <= 1'b0;
`ifdef SEQ_STEP_EN
            step_pend_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            cnt_r    <= cnt_s;
            len_r    <= len_s;
            guard_r  <= guard_s;
            fields_r <= fields_s;
            issue_r  <= issue_s;
            busy_r   <= busy_s;
            halted_r <= halted_s;
            abort_r  <= abort_s;
`ifdef SEQ_STEP_EN
            step_pend_r <= step_pend_s;
`endif
        end
    end

    assign instr      = fields_r[33:31];
    assign reg1       = fields_r[30:26];
    assign reg2       = fields_r[25:21];
    assign reg3       = fields_r[20:16];
    assign imm        = fields_r[15:0];
    assign issue      = issue_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign pc         = pc_r;
    assign issued_cnt = cnt_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected issue
// records, a negedge monitor pops and compares them as issues appear.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'd0;
    logic [33:0] prog_data = 34'h0;
    logic [4:0]  prog_len = 5'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        done = 1'b1;
    logic [2:0]  instr;
    logic [4:0]  reg1, reg2, reg3;
    logic [15:0] imm;
    logic        issue, busy, halted;
    logic [3:0]  pc;
    logic [4:0]  issued_cnt;

    instr_sequencer #(.DEPTH(16), .PC_W(4), .GUARD(2)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .abort(abort), .done(done),
`ifdef SEQ_STEP_EN
        .step_mode(1'b0), .step(1'b0),
`endif
        .instr(instr), .reg1(reg1), .reg2(reg2), .reg3(reg3), .imm(imm),
        .issue(issue), .busy(busy), .halted(halted), .pc(pc),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] f;
        logic [4:0]  cnt;
        logic [3:0]  pc;
        int          gap;
    } rec_t;

    rec_t        exp_q[$];
    logic [33:0] prog [9];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [33:0] held = 34'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected record per issue pulse and checks holding.
    always @(negedge clk) begin
        rec_t r;
        logic [33:0] fl;
        fl = {instr, reg1, reg2, reg3, imm};
        if (issue) begin
            chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("fields", 64'(fl), 64'(r.f));
                chk("issued_cnt", 64'(issued_cnt), 64'(r.cnt));
                chk("pc", 64'(pc), 64'(r.pc));
                if (r.gap != 0) chk("issue_gap", 64'(cyc - last_cyc), 64'(r.gap));
            end
            last_cyc = cyc;
            held = fl;
        end else if (busy) begin
            chk("fields_held", 64'(fl), 64'(held));
        end else begin
            held = 34'h0;
            chk("idle_zero", 64'(fl), 64'd0);
        end
    end

    task automatic push_run(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r.f   = prog[i];
            r.cnt = 5'(i + 1);
            r.pc  = 4'(i + 1);
            r.gap = (i == 0) ? 0 : 4;
            exp_q.push_back(r);
        end
    endtask

    task automatic do_start(input logic [4:0] len);
        prog_len = len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("halted_cleared", 64'(halted), 64'd0);
    endtask

    task automatic wait_issue();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!issue && k < 100);
        chk("issue_timeout", 64'(issue), 64'd1);
    endtask

    task automatic wait_halted();
        int k = 0;
        while (!halted && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("halt_timeout", 64'(halted), 64'd1);
    endtask

    task automatic check_end(input logic [4:0] cnt, input logic [3:0] epc);
        chk("end_halted", 64'(halted), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_cnt", 64'(issued_cnt), 64'(cnt));
        chk("end_pc", 64'(pc), 64'(epc));
        chk("end_fields_zero", 64'({instr, reg1, reg2, reg3, imm}), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = {3'b000, 5'd0, 5'd0, 5'd1, 16'd17};
        prog[1] = {3'b011, 5'd1, 5'd0, 5'd2, 16'hFFF7};
        prog[2] = {3'b010, 5'd2, 5'd1, 5'd3, 16'd100};
        prog[3] = {3'b100, 5'd3, 5'd2, 5'd4, 16'h1234};
        prog[4] = {3'b101, 5'd4, 5'd3, 5'd5, 16'hABCD};
        prog[5] = {3'b110, 5'd5, 5'd4, 5'd6, 16'h0001};
        prog[6] = {3'b111, 5'd6, 5'd5, 5'd7, 16'h8000};
        prog[7] = {3'b010, 5'd7, 5'd6, 5'd8, 16'h00FF};
        prog[8] = {3'b001, 5'd6, 5'd0, 5'd0, 16'd0};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_fields", 64'({instr, reg1, reg2, reg3, imm}), 64'd0);
        chk("rst_flags", 64'({issue, busy, halted}), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_cnt", 64'(issued_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load program while idle
        for (int i = 0; i < 9; i++) begin
            prog_we = 1'b1;
            prog_addr = 4'(i);
            prog_data = prog[i];
            @(posedge clk);
            #1;
        end
        prog_we = 1'b0;

        // 1: full 9-word run with done tied high
        done = 1'b1;
        push_run(9);
        do_start(5'd9);
        wait_halted();
        check_end(5'd9, 4'd9);

        // 2: done low for 20 cycles after the 2nd issue; 3: write while busy
        push_run(4);
        exp_q[2].gap = 22;
        do_start(5'd4);
        wait_issue();
        wait_issue();
        done = 1'b0;
        prog_we = 1'b1;
        prog_addr = 4'd3;
        prog_data = 34'h3_DEAD_BEEF;
        repeat (20) @(posedge clk);
        #1;
        prog_we = 1'b0;
        done = 1'b1;
        wait_halted();
        check_end(5'd4, 4'd4);

        // 3: rerun shows mem[3] unchanged
        push_run(4);
        do_start(5'd4);
        wait_halted();
        check_end(5'd4, 4'd4);

        // 4: zero-length run
        do_start(5'd0);
        @(posedge clk);
        #1;
        chk("len0_halted", 64'(halted), 64'd1);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_cnt", 64'(issued_cnt), 64'd0);

        // 5: abort during guard wait of the 4th instruction
        push_run(4);
        do_start(5'd9);
        repeat (4) wait_issue();
        done = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_still_busy", 64'(busy), 64'd1);
        done = 1'b1;
        wait_halted();
        check_end(5'd4, 4'd4);

        // 6: reset during the 6th instruction, then restart
        push_run(6);
        do_start(5'd9);
        repeat (6) wait_issue();
        rst_n = 1'b0;
        #1;
        chk("midrst_fields", 64'({instr, reg1, reg2, reg3, imm}), 64'd0);
        chk("midrst_flags", 64'({issue, busy, halted}), 64'd0);
        chk("midrst_pc_cnt", 64'({pc, issued_cnt}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_idle", 64'(busy), 64'd0);
        push_run(9);
        do_start(5'd9);
        wait_halted();
        check_end(5'd9, 4'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
